// File: rtl/audio_boxcar_decimator_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_boxcar_decimator_if
// Purpose  : Sample/frame bus between the SID audio source, decimator and I2S.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_boxcar_decimator_if #(
  parameter int BITS = 24
);
  logic                   in_valid;
  logic signed [BITS-1:0] in_left;
  logic signed [BITS-1:0] in_right;
  logic                   frame;
  logic                   ready;
  logic                   out_valid;
  logic signed [BITS-1:0] out_left;
  logic signed [BITS-1:0] out_right;

  modport master (
    output in_valid, in_left, in_right, frame,
    input  ready, out_valid, out_left, out_right
  );

  modport slave (
    input  in_valid, in_left, in_right, frame,
    output ready, out_valid, out_left, out_right
  );
endinterface
`default_nettype wire

// File: rtl/audio_boxcar_decimator.sv
`default_nettype none
// ============================================================================
// Module   : audio_boxcar_decimator
// Purpose  : Stereo 2^LOG2N-tap boxcar average of SID samples, latched per I2S frame.
// Revision : 1.0 - initial release
// ============================================================================

module audio_boxcar_channel #(
  parameter int BITS  = 24,
  parameter int LOG2N = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   run,
  input  wire logic                   in_valid,
  input  wire logic                   frame,
  input  wire logic [LOG2N-1:0]       wp,
  input  wire logic signed [BITS-1:0] sample,
  output logic signed [BITS-1:0]      avg
);
  localparam int N  = 1 << LOG2N;
  localparam int SW = BITS + LOG2N;

  logic signed [BITS-1:0] r_mem [N];
  logic signed [SW-1:0]   r_sum;
  logic signed [BITS-1:0] r_avg;
  logic signed [BITS-1:0] w_old;
  logic signed [SW-1:0]   w_old_ext;
  logic signed [SW-1:0]   w_new_ext;

  assign w_old     = r_mem[wp];
  assign w_old_ext = {{LOG2N{w_old[BITS-1]}}, w_old};
  assign w_new_ext = {{LOG2N{sample[BITS-1]}}, sample};
  assign avg       = r_avg;

  // Buffer needs no reset: the CLEAR sweep zeroes every entry before RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        r_mem[wp] <= '0;
      end else if (in_valid) begin
        r_mem[wp] <= sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_avg <= '0;
    end else if (run) begin
      // Upper BITS of the sum are exactly sum >>> LOG2N (floor toward -inf).
      if (frame) begin
        r_avg <= r_sum[SW-1:LOG2N];
      end
      if (in_valid) begin
        r_sum <= r_sum - w_old_ext + w_new_ext;
      end
    end
  end

`ifndef SYNTHESIS
  logic signed [SW-1:0] w_chk;

  always_comb begin
    w_chk = '0;
    for (int i = 0; i < N; i++) begin
      w_chk = w_chk + {{LOG2N{r_mem[i][BITS-1]}}, r_mem[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && run) begin
      a_sum_matches_buffer : assert (r_sum == w_chk);
    end
  end
`endif
endmodule

module audio_boxcar_decimator #(
  parameter int BITS  = 24,
  parameter int LOG2N = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  audio_boxcar_decimator_if.slave   bus
);
  localparam logic [0:0]       c_ST_CLEAR = 1'b0;
  localparam logic [0:0]       c_ST_RUN   = 1'b1;
  localparam logic [LOG2N-1:0] c_WP_LAST  = '1;
  localparam logic [LOG2N-1:0] c_WP_ONE   = LOG2N'(1);

  logic [0:0]             r_state;
  logic [LOG2N-1:0]       r_wp;
  logic                   r_out_valid;
  logic                   w_run;
  logic signed [BITS-1:0] w_sample [2];
  logic signed [BITS-1:0] w_avg    [2];

  assign w_run       = (r_state == c_ST_RUN);
  assign w_sample[0] = bus.in_left;
  assign w_sample[1] = bus.in_right;

  assign bus.ready     = w_run;
  assign bus.out_valid = r_out_valid;
  assign bus.out_left  = w_avg[0];
  assign bus.out_right = w_avg[1];

  // Pointer wraps naturally at N-1, which also ends the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_CLEAR;
      r_wp        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_ST_CLEAR: begin
          r_out_valid <= 1'b0;
          r_wp        <= r_wp + c_WP_ONE;
          if (r_wp == c_WP_LAST) begin
            r_state <= c_ST_RUN;
          end
        end
        default: begin
          r_out_valid <= bus.frame;
          if (bus.in_valid) begin
            r_wp <= r_wp + c_WP_ONE;
          end
        end
      endcase
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_chan
    audio_boxcar_channel #(
      .BITS  (BITS),
      .LOG2N (LOG2N)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .run      (w_run),
      .in_valid (bus.in_valid),
      .frame    (bus.frame),
      .wp       (r_wp),
      .sample   (w_sample[c]),
      .avg      (w_avg[c])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_audio_boxcar_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_boxcar_decimator
// Purpose  : Scoreboard bench for audio_boxcar_decimator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_boxcar_decimator;
  localparam int BITS = 24;
  localparam int N    = 16;

  typedef struct {
    int l;
    int r;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_boxcar_decimator_if #(.BITS(BITS)) bus ();

  audio_boxcar_decimator #(.BITS(BITS), .LOG2N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  pair_t sb_q[$];
  int    hist_l[$];
  int    hist_r[$];
  bit    m_armed  = 1'b0;
  bit    m_run    = 1'b0;
  int    m_cnt    = 0;
  int    m_hold_l = 0;
  int    m_hold_r = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int floor_avg(input int h[$]);
    longint s = 0;
    longint q;
    foreach (h[i]) s += h[i];
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic clear_hist();
    hist_l = {};
    hist_r = {};
    for (int i = 0; i < N; i++) begin
      hist_l.push_back(0);
      hist_r.push_back(0);
    end
  endtask

  // One clock of stimulus; the model advances with what the DUT sampled at that edge.
  task automatic tick(input bit v, input int l, input int r, input bit f, input bit rs);
    pair_t e;
    bus.in_valid = v;
    bus.in_left  = l[BITS-1:0];
    bus.in_right = r[BITS-1:0];
    bus.frame    = f;
    rst          = rs;
    @(posedge clk);
    if (rs) begin
      m_armed  = 1'b1;
      m_run    = 1'b0;
      m_cnt    = 0;
      m_hold_l = 0;
      m_hold_r = 0;
      clear_hist();
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == N) m_run = 1'b1;
    end else begin
      if (f) begin
        e.l = floor_avg(hist_l);
        e.r = floor_avg(hist_r);
        sb_q.push_back(e);
      end
      if (v) begin
        void'(hist_l.pop_front());
        void'(hist_r.pop_front());
        hist_l.push_back(l);
        hist_r.push_back(r);
      end
    end
    #1;
    if (m_armed) check("ready", int'(bus.ready), int'(m_run));
  endtask

  task automatic fill(input int l, input int r);
    for (int i = 0; i < N; i++) tick(1'b1, l, r, 1'b0, 1'b0);
  endtask

  task automatic frame_expect(input string tag, input int el, input int er);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    check({tag, "_l"}, int'(bus.out_left), el);
    check({tag, "_r"}, int'(bus.out_right), er);
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (m_armed) begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_left", int'(bus.out_left), e.l);
          check("sb_right", int'(bus.out_right), e.r);
          m_hold_l = e.l;
          m_hold_r = e.r;
        end
      end else begin
        check("hold_left", int'(bus.out_left), m_hold_l);
        check("hold_right", int'(bus.out_right), m_hold_r);
      end
    end
  end

  initial begin
    clear_hist();
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    bus.frame    = 1'b0;

    // Reset and CLEAR: samples offered during the sweep must be dropped.
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0, 1'b1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_left", int'(bus.out_left), 0);
    check("rst_out_right", int'(bus.out_right), 0);
    for (int i = 0; i < N + 1; i++) tick(1'b1, 32'h100000, 0, 1'b0, 1'b0);
    frame_expect("clear_one_sample", 32'h010000, 0);

    fill(1000, -1000);
    frame_expect("step", 1000, -1000);
    tick(1'b0, 0, 0, 1'b0, 1'b0);

    for (int k = N - 1; k >= 0; k--) begin
      tick(1'b1, 0, 0, 1'b0, 1'b0);
      frame_expect("evict", (1000 * k) / N, -((1000 * k + N - 1) / N));
    end

    fill(-1, 1);
    frame_expect("neg_one", -1, 1);
    fill(32'h7FFFFF, -8388608);
    frame_expect("max_min", 32'h7FFFFF, -8388608);
    fill(-8388608, 32'h7FFFFF);
    frame_expect("min_max", -8388608, 32'h7FFFFF);

    fill(160, 160);
    tick(1'b1, 320, 320, 1'b1, 1'b0);
    check("simul_pre_l", int'(bus.out_left), 160);
    check("simul_pre_r", int'(bus.out_right), 160);
    frame_expect("simul_post", 170, 170);

    // Reset pulse inside a continuous stream, frames keep arriving during CLEAR.
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, i * 7 - 100, 100 - i * 3, (i % 5) == 0, i == 10);
    end
    fill(50, -50);
    frame_expect("after_midrst", 50, -50);
    tick(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) tick(1'b0, 0, 0, 1'b1, 1'b0);
    frame_expect("restart_zero", 0, 0);

    repeat (3) tick(1'b0, 0, 0, 1'b0, 1'b0);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/audio_boxcar_decimator.md
# audio_boxcar_decimator

Stereo boxcar decimator between the SID API audio output and the I2S serializer. Sums the last 2^LOG2N SID samples per channel, one sample per phi2 cycle (~1 MHz), in a circular buffer with a running sum. On each I2S frame request it latches the average, so every frame carries a low-passed sample rather than a single aliased phi2 sample. Runs in the 24 MHz domain (clk_24 / rst_24 at the top level).

## Interface
- BITS, 24: signed sample width per channel.
- LOG2N, 4: log2 of the window length; window N = 2^LOG2N samples.

- clk  in  1  system clock (clk_24).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle strobe: new SID sample on in_left / in_right.
- in_left  in  BITS  signed left sample.
- in_right  in  BITS  signed right sample.
- frame  in  1  one-cycle strobe, already synchronized to clk: I2S frame start, i.e. request the next output sample.
- ready  out  1  high when in RUN; low during CLEAR.
- out_valid  out  1  one-cycle strobe: out_left / out_right updated.
- out_left  out  BITS  signed averaged left sample, held between updates.
- out_right  out  BITS  signed averaged right sample, held between updates.

## Operation
- Storage: two register arrays of N entries × BITS (left, right). One write pointer wp, LOG2N bits, shared by both channels. Running sums sum_l and sum_r, signed, BITS+LOG2N bits each.
- State CLEAR, entered on rst:
  - Writes 0 to entry wp of both arrays each cycle, and wp increments.
  - After the write to entry N-1, moves to RUN with wp wrapped to 0.
  - Lasts exactly N cycles after rst deasserts.
  - in_valid is ignored; frame is ignored, so out_valid stays 0.
- State RUN, in_valid=1:
  - sum <= sum − buf[wp] + in.
  - buf[wp] <= in.
  - wp <= wp + 1, wrapping N-1 → 0.
  - All three updates happen in one cycle. Back-to-back in_valid is supported.
- State RUN, frame=1:
  - out_x <= sum_x >>> LOG2N (arithmetic shift, floor toward −∞).
  - out_valid <= 1 for one cycle.
- in_valid and frame in the same cycle: the output latches the pre-update sum, and the sample update still occurs.
- Arithmetic: the sum width never overflows, since N samples of BITS bits fit in BITS+LOG2N bits. The shifted result always fits in BITS. No saturation logic is required.
- Invariant in RUN: sum_x equals the exact sum of buffer contents. Verify with an assertion.
- rst asserted mid-operation: the next cycle starts CLEAR and all state returns to reset values. Samples and frames in flight are discarded.

## Timing
- Reset values: state=CLEAR, wp=0, sum_l=sum_r=0, ready=0, out_valid=0, out_left=out_right=0.
- ready rises on the first RUN cycle: registered, N cycles after rst falls.
- Latency, in_valid to effect on sum: 1 cycle. A sample accepted in cycle t is visible to a frame in cycle t+1 or later.
- Latency, frame to out_valid/out data: 1 cycle, with both registered together.
- out_left / out_right change only in the cycle out_valid is high.
- frame rate (48 kHz) and in_valid rate (~1 MHz) are independent. No ordering is required between them.

## Test plan
- Reset/clear:
  - Stimulus: assert rst 3 cycles, release, hold in_valid=1 with in_left=0x100000.
  - Required: ready=0 for 16 cycles, outputs 0, samples ignored. A frame at cycle 17 after release yields out_left=0x010000 (one accepted sample / 16).
- Step fill:
  - Stimulus: 16 in_valid with in_left=1000, in_right=−1000, then frame.
  - Required: out_left=1000, out_right=−1000, out_valid high exactly 1 cycle, 1 cycle after frame.
- Wrap-around eviction:
  - Stimulus: after the step fill, 16 more samples of in_left=0 with a frame after each.
  - Required: out_left steps 937, 875, …, 62, 0, i.e. floor(1000·k/16) for k=15 down to 0.
- Floor rounding / extremes:
  - Stimulus: fill with in_left=−1.
  - Required: out_left=−1.
  - Stimulus: fill with in_left=0x7FFFFF.
  - Required: out_left=0x7FFFFF, no overflow.
  - Stimulus: fill with in_left=0x800000.
  - Required: out_left=0x800000.
- Simultaneous events:
  - Stimulus: buffer full of 160, then in_valid (in_left=320) and frame in the same cycle.
  - Required: out_left=160 (pre-update sum).
  - Stimulus: a following frame.
  - Required: out_left=170.
- Mid-operation reset:
  - Stimulus: rst pulsed for 1 cycle during a continuous in_valid stream.
  - Required: ready drops for 16 cycles, sums restart from 0, no out_valid during CLEAR.
  - Check: the running-sum invariant holds throughout.
